// File: rtl/stats_dma_latency_accum.sv
// DMA latency record accumulator with snapshot shadow bank and register read port.
// Live counters update on each accepted record; shadows freeze on a snapshot pulse.
module stats_dma_latency_accum #(
    parameter int COUNT_WIDTH  = 16,
    parameter int TAG_WIDTH    = 8,
    parameter int LEN_WIDTH    = 16,
    parameter int STATUS_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    input  logic [LEN_WIDTH-1:0]    in_len,
    input  logic [STATUS_WIDTH-1:0] in_status,
    input  logic [COUNT_WIDTH-1:0]  in_latency,
    input  logic                    in_valid,
    input  logic                    snapshot,
    input  logic                    clear_on_snap,
    input  logic [4:0]              reg_rd_addr,
    input  logic                    reg_rd_en,
    output logic [31:0]             reg_rd_data,
    output logic                    reg_rd_ack
);

    logic unused_tag;
    assign unused_tag = ^in_tag;

    logic [31:0]            op_cnt_q, op_cnt_d;
    logic [31:0]            err_cnt_q, err_cnt_d;
    logic [63:0]            byte_tot_q, byte_tot_d;
    logic [63:0]            lat_tot_q, lat_tot_d;
    logic [COUNT_WIDTH-1:0] lat_min_q, lat_min_d;
    logic [COUNT_WIDTH-1:0] lat_max_q, lat_max_d;
    logic [31:0]            hist_q [16];
    logic [31:0]            hist_d [16];

    logic [31:0]            sh_op_q;
    logic [31:0]            sh_err_q;
    logic [63:0]            sh_byte_q;
    logic [63:0]            sh_lat_q;
    logic [COUNT_WIDTH-1:0] sh_min_q;
    logic [COUNT_WIDTH-1:0] sh_max_q;
    logic [31:0]            sh_hist_q [16];
    logic [31:0]            snap_seq_q;

    logic [31:0]            rd_data_q, rd_data_d;
    logic                   rd_ack_q;
    logic [3:0]             bin;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [63:0] sat_add64(input logic [63:0] a,
                                              input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

    // floor(log2) of the latency, with 0/1 folded into bin 0 and >= 2^15 into bin 15
    function automatic logic [3:0] hist_bin(input logic [COUNT_WIDTH-1:0] lat);
        logic [31:0] v;
        logic [3:0]  b;
        v = 32'(lat);
        b = 4'd0;
        for (int i = 1; i < 15; i++) begin
            if (v[i]) b = 4'(i);
        end
        if (|v[31:15]) b = 4'd15;
        return b;
    endfunction

    assign bin = hist_bin(in_latency);

    always_comb begin
        op_cnt_d   = op_cnt_q;
        err_cnt_d  = err_cnt_q;
        byte_tot_d = byte_tot_q;
        lat_tot_d  = lat_tot_q;
        lat_min_d  = lat_min_q;
        lat_max_d  = lat_max_q;
        hist_d     = hist_q;
        if (snapshot && clear_on_snap) begin
            op_cnt_d   = '0;
            err_cnt_d  = '0;
            byte_tot_d = '0;
            lat_tot_d  = '0;
            lat_min_d  = '1;
            lat_max_d  = '0;
            for (int i = 0; i < 16; i++) hist_d[i] = '0;
        end
        if (in_valid) begin
            op_cnt_d = sat_inc32(op_cnt_d);
            if (in_status != '0) begin
                err_cnt_d = sat_inc32(err_cnt_d);
            end else begin
                byte_tot_d = sat_add64(byte_tot_d, 64'(in_len));
                lat_tot_d  = sat_add64(lat_tot_d, 64'(in_latency));
                if (in_latency < lat_min_d) lat_min_d = in_latency;
                if (in_latency > lat_max_d) lat_max_d = in_latency;
                hist_d[bin] = sat_inc32(hist_d[bin]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_q   <= '0;
            err_cnt_q  <= '0;
            byte_tot_q <= '0;
            lat_tot_q  <= '0;
            lat_min_q  <= '1;
            lat_max_q  <= '0;
            for (int i = 0; i < 16; i++) hist_q[i] <= '0;
        end else begin
            op_cnt_q   <= op_cnt_d;
            err_cnt_q  <= err_cnt_d;
            byte_tot_q <= byte_tot_d;
            lat_tot_q  <= lat_tot_d;
            lat_min_q  <= lat_min_d;
            lat_max_q  <= lat_max_d;
            hist_q     <= hist_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_op_q    <= '0;
            sh_err_q   <= '0;
            sh_byte_q  <= '0;
            sh_lat_q   <= '0;
            sh_min_q   <= '1;
            sh_max_q   <= '0;
            snap_seq_q <= '0;
            for (int i = 0; i < 16; i++) sh_hist_q[i] <= '0;
        end else if (snapshot) begin
            sh_op_q    <= op_cnt_q;
            sh_err_q   <= err_cnt_q;
            sh_byte_q  <= byte_tot_q;
            sh_lat_q   <= lat_tot_q;
            sh_min_q   <= lat_min_q;
            sh_max_q   <= lat_max_q;
            sh_hist_q  <= hist_q;
            snap_seq_q <= snap_seq_q + 32'd1;
        end
    end

    // min is meaningless with no OK ops in the interval, so it reads as 0
    always_comb begin
        rd_data_d = '0;
        if (reg_rd_addr[4]) begin
            rd_data_d = sh_hist_q[reg_rd_addr[3:0]];
        end else begin
            case (reg_rd_addr[3:0])
                4'd0: rd_data_d = sh_op_q;
                4'd1: rd_data_d = sh_err_q;
                4'd2: rd_data_d = sh_byte_q[31:0];
                4'd3: rd_data_d = sh_byte_q[63:32];
                4'd4: rd_data_d = sh_lat_q[31:0];
                4'd5: rd_data_d = sh_lat_q[63:32];
                4'd6: rd_data_d = (sh_op_q == sh_err_q) ? 32'd0 : 32'(sh_min_q);
                4'd7: rd_data_d = 32'(sh_max_q);
                4'd8: rd_data_d = snap_seq_q;
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
        end else begin
            rd_data_q <= reg_rd_en ? rd_data_d : 32'd0;
            rd_ack_q  <= reg_rd_en;
        end
    end

    assign reg_rd_data = rd_data_q;
    assign reg_rd_ack  = rd_ack_q;

endmodule

// File: tb/tb_stats_dma_latency_accum.sv
// Directed bench for stats_dma_latency_accum with a behavioural reference model.
// Model runs at each rising edge; outputs are compared 1ns after every edge.
module tb_stats_dma_latency_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_tag;
    logic [15:0] in_len;
    logic [3:0]  in_status;
    logic [15:0] in_latency;
    logic        in_valid;
    logic        snapshot;
    logic        clear_on_snap;
    logic [4:0]  reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_ack;

    int total = 0;
    int bad = 0;

    stats_dma_latency_accum dut (
        .clk(clk), .rst_n(rst_n), .in_tag(in_tag), .in_len(in_len),
        .in_status(in_status), .in_latency(in_latency), .in_valid(in_valid),
        .snapshot(snapshot), .clear_on_snap(clear_on_snap),
        .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data), .reg_rd_ack(reg_rd_ack)
    );

    always #5 clk = ~clk;

    localparam longint unsigned M32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint unsigned M64 = 64'hFFFF_FFFF_FFFF_FFFF;

    // live and shadow statistics as plain numbers
    longint unsigned l_op, l_err, l_byte, l_lat, l_min, l_max;
    longint unsigned l_hist [16];
    longint unsigned s_op, s_err, s_byte, s_lat, s_min, s_max;
    longint unsigned s_hist [16];
    longint unsigned seq;
    logic        exp_ack = 1'b0;
    logic [31:0] exp_data = '0;
    bit          started = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic longint unsigned add_sat(input longint unsigned a,
                                                input longint unsigned b,
                                                input longint unsigned lim);
        return (a > lim - b) ? lim : a + b;
    endfunction

    function automatic int log_bin(input longint unsigned lat);
        int b = 0;
        longint unsigned x = lat;
        while (x > 1) begin
            x = x >> 1;
            b++;
        end
        return (b > 15) ? 15 : b;
    endfunction

    function automatic void clear_live();
        l_op = 0; l_err = 0; l_byte = 0; l_lat = 0;
        l_min = 64'hFFFF; l_max = 0;
        for (int i = 0; i < 16; i++) l_hist[i] = 0;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a >= 5'd16) return 32'(s_hist[a - 5'd16]);
        case (a)
            5'd0: return 32'(s_op);
            5'd1: return 32'(s_err);
            5'd2: return s_byte[31:0];
            5'd3: return s_byte[63:32];
            5'd4: return s_lat[31:0];
            5'd5: return s_lat[63:32];
            5'd6: return (s_op - s_err == 0) ? 32'd0 : 32'(s_min);
            5'd7: return 32'(s_max);
            5'd8: return 32'(seq);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            clear_live();
            s_op = 0; s_err = 0; s_byte = 0; s_lat = 0;
            s_min = 64'hFFFF; s_max = 0; seq = 0;
            for (int i = 0; i < 16; i++) s_hist[i] = 0;
            exp_ack = 1'b0;
            exp_data = '0;
            started = 1;
        end else begin
            exp_ack = reg_rd_en;
            exp_data = reg_rd_en ? mread(reg_rd_addr) : 32'd0;
            if (snapshot) begin
                s_op = l_op; s_err = l_err; s_byte = l_byte; s_lat = l_lat;
                s_min = l_min; s_max = l_max; s_hist = l_hist;
                seq = (seq + 1) & M32;
                if (clear_on_snap) clear_live();
            end
            if (in_valid) begin
                l_op = add_sat(l_op, 1, M32);
                if (in_status != 0) begin
                    l_err = add_sat(l_err, 1, M32);
                end else begin
                    l_byte = add_sat(l_byte, in_len, M64);
                    l_lat = add_sat(l_lat, in_latency, M64);
                    if (in_latency < l_min) l_min = in_latency;
                    if (in_latency > l_max) l_max = in_latency;
                    l_hist[log_bin(in_latency)] =
                        add_sat(l_hist[log_bin(in_latency)], 1, M32);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("model_ack", 64'(reg_rd_ack), 64'(exp_ack));
            chk("model_data", 64'(reg_rd_data), 64'(exp_data));
        end
    end

    task automatic rec(input logic [15:0] len, input logic [15:0] lat,
                       input logic [3:0] st);
        in_valid = 1'b1; in_len = len; in_latency = lat; in_status = st;
        in_tag = in_tag + 8'd1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic snap(input logic clr);
        snapshot = 1'b1; clear_on_snap = clr;
        @(negedge clk);
        snapshot = 1'b0; clear_on_snap = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [4:0] a,
                      input logic [31:0] exp);
        reg_rd_en = 1'b1; reg_rd_addr = a;
        @(negedge clk);
        reg_rd_en = 1'b0;
        chk(nm, {31'd0, reg_rd_ack, reg_rd_data}, {31'd0, 1'b1, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_tag = '0; in_len = '0; in_status = '0;
        in_latency = '0; in_valid = 1'b0; snapshot = 1'b0;
        clear_on_snap = 1'b0; reg_rd_addr = '0; reg_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", {31'd0, reg_rd_ack, reg_rd_data}, 64'd0);
        rst_n = 1'b1;

        snap(1'b0);
        for (int a = 0; a < 8; a++) rd("empty", 5'(a), 32'd0);
        rd("empty_seq", 5'd8, 32'd1);

        rec(16'd64, 16'd10, 4'd0);
        rec(16'd128, 16'd3, 4'd0);
        rec(16'd256, 16'd40000, 4'd0);
        snap(1'b1);
        rd("ok_op", 5'd0, 32'd3);
        rd("ok_err", 5'd1, 32'd0);
        rd("ok_byte", 5'd2, 32'd448);
        rd("ok_byte_hi", 5'd3, 32'd0);
        rd("ok_lat", 5'd4, 32'd40013);
        rd("ok_min", 5'd6, 32'd3);
        rd("ok_max", 5'd7, 32'd40000);
        rd("ok_h0", 5'd16, 32'd0);
        rd("ok_h1", 5'd17, 32'd1);
        rd("ok_h3", 5'd19, 32'd1);
        rd("ok_h15", 5'd31, 32'd1);
        rd("ok_seq", 5'd8, 32'd2);

        rec(16'd32, 16'd5, 4'd2);
        snap(1'b1);
        rd("err_op", 5'd0, 32'd1);
        rd("err_err", 5'd1, 32'd1);
        rd("err_lat", 5'd4, 32'd0);
        rd("err_min", 5'd6, 32'd0);
        rd("err_h2", 5'd18, 32'd0);

        in_valid = 1'b1; in_len = 16'd1; in_latency = 16'd7; in_status = '0;
        @(negedge clk);
        in_len = 16'd2; in_latency = 16'd100;
        snapshot = 1'b1; clear_on_snap = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; snapshot = 1'b0; clear_on_snap = 1'b0;
        rd("clr_op", 5'd0, 32'd1);
        rd("clr_lat", 5'd4, 32'd7);
        snap(1'b0);
        rd("new_op", 5'd0, 32'd1);
        rd("new_lat", 5'd4, 32'd100);
        rd("new_byte", 5'd2, 32'd2);

        dut.op_cnt_q = 32'hFFFF_FFFF;
        l_op = M32;
        rec(16'd8, 16'd20, 4'd0);
        snap(1'b0);
        rd("sat_op", 5'd0, 32'hFFFF_FFFF);

        reg_rd_en = 1'b1; reg_rd_addr = 5'd0;
        @(negedge clk);
        chk("strm0", {31'd0, reg_rd_ack, reg_rd_data}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        reg_rd_addr = 5'd6;
        @(negedge clk);
        chk("strm6", {31'd0, reg_rd_ack, reg_rd_data}, {31'd0, 1'b1, 32'd20});
        reg_rd_addr = 5'd20;
        @(negedge clk);
        chk("strm20", {31'd0, reg_rd_ack, reg_rd_data}, {31'd0, 1'b1, 32'd1});
        reg_rd_en = 1'b0;
        @(negedge clk);
        chk("strm_idle", {31'd0, reg_rd_ack, reg_rd_data}, 64'd0);

        reg_rd_en = 1'b1; reg_rd_addr = 5'd0;
        @(negedge clk);
        chk("rst_rd0", {31'd0, reg_rd_ack, reg_rd_data}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        reg_rd_addr = 5'd6; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rd1", {31'd0, reg_rd_ack, reg_rd_data}, 64'd0);
        rst_n = 1'b1; reg_rd_en = 1'b0;
        snap(1'b0);
        rd("post_rst_op", 5'd0, 32'd0);
        rd("post_rst_seq", 5'd8, 32'd1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
